// File: rtl/alu_pkg.sv
// Shared ALU definitions: opcode encoding and the illegal-opcode boundary.
package alu_pkg;

   localparam int OPW             = 4;
   localparam int ALU_ILLEGAL_MIN = 14;

   typedef enum logic [OPW-1:0] {
      ALU_ADD = 4'd0,
      ALU_SUB = 4'd1,
      ALU_AND = 4'd2,
      ALU_OR  = 4'd3,
      ALU_XOR = 4'd4,
      ALU_SEQ = 4'd5,
      ALU_SNE = 4'd6,
      ALU_SLE = 4'd7,
      ALU_SGE = 4'd8,
      ALU_SLT = 4'd9,
      ALU_SGT = 4'd10,
      ALU_SLL = 4'd11,
      ALU_SRL = 4'd12,
      ALU_SRA = 4'd13
   } alu_op_e;

   // True for the opcodes above the defined table
   function automatic logic op_is_illegal(input logic [OPW-1:0] op);
      return int'(op) >= ALU_ILLEGAL_MIN;
   endfunction

endpackage

// File: rtl/alu_core.sv
// Purely combinational ALU: add/sub, bitwise logic, compares and shifts.
// Undefined opcodes produce y = 0 with illegal raised.
module alu_core
   import alu_pkg::*;
#(
   parameter int W = 32
) (
   input  logic [OPW-1:0] op,
   input  logic [W-1:0]   a,
   input  logic [W-1:0]   b,
   output logic [W-1:0]   y,
   output logic           illegal
);

   localparam int SHW = $clog2(W);
   localparam logic [W-1:0] ONE  = {{(W-1){1'b0}}, 1'b1};
   localparam logic [W-1:0] ZERO = '0;

   // The shift amount is the whole of b; any bit above the index range
   // means the shift moves every bit out of the word.
   logic            shift_big;
   logic [SHW-1:0]  shamt;
   logic            lt_u;
   logic            lt_s;
   logic            eq;

   assign shift_big = |(b >> SHW);
   assign shamt     = b[SHW-1:0];
   assign eq        = (a == b);
   assign lt_u      = (a < b);
   assign lt_s      = ($signed(a) < $signed(b));

   // Opcode decode and result selection
   always_comb begin
      y       = ZERO;
      illegal = 1'b0;
      case (alu_op_e'(op))
         ALU_ADD: y = a + b;
         ALU_SUB: y = a - b;
         ALU_AND: y = a & b;
         ALU_OR:  y = a | b;
         ALU_XOR: y = a ^ b;
         ALU_SEQ: y = eq ? ONE : ZERO;
         ALU_SNE: y = eq ? ZERO : ONE;
         ALU_SLE: y = (lt_u || eq) ? ONE : ZERO;
         ALU_SGE: y = lt_u ? ZERO : ONE;
         ALU_SLT: y = lt_s ? ONE : ZERO;
         ALU_SGT: y = (lt_s || eq) ? ZERO : ONE;
         ALU_SLL: y = shift_big ? ZERO : (a << shamt);
         ALU_SRL: y = shift_big ? ZERO : (a >> shamt);
         ALU_SRA: y = shift_big ? {W{a[W-1]}} : W'($signed(a) >>> shamt);
         default: begin
            y       = ZERO;
            illegal = op_is_illegal(op);
         end
      endcase
   end

endmodule

// File: rtl/alu_share_arbiter.sv
// Two requesters share one ALU through a round-robin arbiter feeding a
// single registered result slot with valid/ready backpressure.
module alu_share_arbiter
   import alu_pkg::*;
#(
   parameter int W    = 32,
   parameter int TAGW = 5
) (
   input  logic            clk,
   input  logic            rst_n,
   input  logic [1:0]      req_valid,
   output logic [1:0]      req_ready,
   input  logic [OPW-1:0]  req0_op,
   input  logic [OPW-1:0]  req1_op,
   input  logic [W-1:0]    req0_a,
   input  logic [W-1:0]    req0_b,
   input  logic [W-1:0]    req1_a,
   input  logic [W-1:0]    req1_b,
   input  logic [TAGW-1:0] req0_tag,
   input  logic [TAGW-1:0] req1_tag,
   output logic            res_valid,
   input  logic            res_ready,
   output logic [W-1:0]    res_data,
   output logic [TAGW-1:0] res_tag,
   output logic            res_src,
   output logic            res_illegal
);

   // Result slot and priority pointer
   logic            res_valid_reg;
   logic [W-1:0]    res_data_reg;
   logic [TAGW-1:0] res_tag_reg;
   logic            res_src_reg;
   logic            res_illegal_reg;
   logic            ptr_reg;

   // Per-port request fields gathered into arrays for selection
   logic [OPW-1:0]  port_op  [2];
   logic [W-1:0]    port_a   [2];
   logic [W-1:0]    port_b   [2];
   logic [TAGW-1:0] port_tag [2];

   logic            slot_free;
   logic [1:0]      grant;
   logic            xfer;
   logic            sel;
   logic [W-1:0]    alu_y;
   logic            alu_illegal;

   assign port_op[0]  = req0_op;
   assign port_op[1]  = req1_op;
   assign port_a[0]   = req0_a;
   assign port_a[1]   = req1_a;
   assign port_b[0]   = req0_b;
   assign port_b[1]   = req1_b;
   assign port_tag[0] = req0_tag;
   assign port_tag[1] = req1_tag;

   // A draining result frees the slot in the same cycle, so a new request
   // can be accepted back-to-back at full rate.
   assign slot_free = !res_valid_reg || res_ready;

   // Round-robin grant: a lone requester always wins, a tie goes to the pointer
   always_comb begin
      grant = 2'b00;
      if (rst_n && slot_free) begin
         if (req_valid == 2'b11) begin
            grant = ptr_reg ? 2'b10 : 2'b01;
         end else begin
            grant = req_valid;
         end
      end
   end

   genvar gi;
   generate
      for (gi = 0; gi < 2; gi++) begin : g_ready
         assign req_ready[gi] = grant[gi];
      end
   endgenerate

   assign xfer = |grant;
   assign sel  = grant[1];

   alu_core #(
      .W (W)
   ) u_alu (
      .op      (port_op[sel]),
      .a       (port_a[sel]),
      .b       (port_b[sel]),
      .y       (alu_y),
      .illegal (alu_illegal)
   );

   // Capture the winner's result, advance the pointer, or drain the slot
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         res_valid_reg   <= 1'b0;
         res_data_reg    <= '0;
         res_tag_reg     <= '0;
         res_src_reg     <= 1'b0;
         res_illegal_reg <= 1'b0;
         ptr_reg         <= 1'b0;
      end else if (xfer) begin
         res_valid_reg   <= 1'b1;
         res_data_reg    <= alu_y;
         res_tag_reg     <= port_tag[sel];
         res_src_reg     <= sel;
         res_illegal_reg <= alu_illegal;
         ptr_reg         <= ~sel;
      end else if (res_valid_reg && res_ready) begin
         res_valid_reg   <= 1'b0;
      end
   end

   assign res_valid   = res_valid_reg;
   assign res_data    = res_data_reg;
   assign res_tag     = res_tag_reg;
   assign res_src     = res_src_reg;
   assign res_illegal = res_illegal_reg;

endmodule

// File: tb/tb_alu_share_arbiter.sv
// Randomised and directed bench for alu_share_arbiter against a
// behavioural model of the arbiter and the ALU opcode table.
module tb_alu_share_arbiter;

   logic        clk = 1'b0;
   logic        rst_n;
   logic [1:0]  req_valid;
   logic [1:0]  req_ready;
   logic [3:0]  req0_op, req1_op;
   logic [31:0] req0_a, req0_b, req1_a, req1_b;
   logic [4:0]  req0_tag, req1_tag;
   logic        res_valid;
   logic        res_ready;
   logic [31:0] res_data;
   logic [4:0]  res_tag;
   logic        res_src;
   logic        res_illegal;

   int n_checks = 0;
   int n_errors = 0;

   // Model state
   logic        m_valid = 1'b0;
   logic [31:0] m_data  = '0;
   logic [4:0]  m_tag   = '0;
   logic        m_src   = 1'b0;
   logic        m_ill   = 1'b0;
   logic        m_ptr   = 1'b0;
   logic        hold_req = 1'b0;

   always #5 clk = ~clk;

   alu_share_arbiter #(.W(32), .TAGW(5)) dut (
      .clk         (clk),
      .rst_n       (rst_n),
      .req_valid   (req_valid),
      .req_ready   (req_ready),
      .req0_op     (req0_op),
      .req1_op     (req1_op),
      .req0_a      (req0_a),
      .req0_b      (req0_b),
      .req1_a      (req1_a),
      .req1_b      (req1_b),
      .req0_tag    (req0_tag),
      .req1_tag    (req1_tag),
      .res_valid   (res_valid),
      .res_ready   (res_ready),
      .res_data    (res_data),
      .res_tag     (res_tag),
      .res_src     (res_src),
      .res_illegal (res_illegal)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Reference ALU written straight from the opcode table
   function automatic logic [31:0] ref_alu(input logic [3:0] op, input logic [31:0] a,
                                           input logic [31:0] b, output logic ill);
      ill = 1'b0;
      case (op)
         4'd0:  return a + b;
         4'd1:  return a - b;
         4'd2:  return a & b;
         4'd3:  return a | b;
         4'd4:  return a ^ b;
         4'd5:  return (a == b) ? 32'd1 : 32'd0;
         4'd6:  return (a != b) ? 32'd1 : 32'd0;
         4'd7:  return (a <= b) ? 32'd1 : 32'd0;
         4'd8:  return (a >= b) ? 32'd1 : 32'd0;
         4'd9:  return ($signed(a) < $signed(b)) ? 32'd1 : 32'd0;
         4'd10: return ($signed(a) > $signed(b)) ? 32'd1 : 32'd0;
         4'd11: return (b >= 32) ? 32'd0 : (a << b);
         4'd12: return (b >= 32) ? 32'd0 : (a >> b);
         4'd13: return (b >= 32) ? {32{a[31]}} : 32'($signed(a) >>> b);
         default: begin
            ill = 1'b1;
            return 32'd0;
         end
      endcase
   endfunction

   task automatic set_req(input int p, input logic [3:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [4:0] tag);
      if (p == 0) begin
         req0_op = op; req0_a = a; req0_b = b; req0_tag = tag;
      end else begin
         req1_op = op; req1_a = a; req1_b = b; req1_tag = tag;
      end
      req_valid[p] = 1'b1;
   endtask

   // One clock: compare DUT against the model mid-cycle, then advance both
   task automatic step();
      logic [1:0]  exp_g;
      logic        ill;
      logic [31:0] d;
      logic        w;
      @(negedge clk);
      exp_g = 2'b00;
      if (rst_n && (!m_valid || res_ready)) begin
         if (req_valid == 2'b11) exp_g = m_ptr ? 2'b10 : 2'b01;
         else                    exp_g = req_valid;
      end
      check("req_ready",   req_ready,   exp_g);
      check("res_valid",   res_valid,   m_valid);
      check("res_data",    res_data,    m_data);
      check("res_tag",     res_tag,     m_tag);
      check("res_src",     res_src,     m_src);
      check("res_illegal", res_illegal, m_ill);
      if (!rst_n) begin
         m_valid = 0; m_data = '0; m_tag = '0; m_src = 0; m_ill = 0; m_ptr = 0;
      end else if (exp_g != 2'b00) begin
         w = exp_g[1];
         if (!w) begin
            d = ref_alu(req0_op, req0_a, req0_b, ill);
            m_tag = req0_tag;
         end else begin
            d = ref_alu(req1_op, req1_a, req1_b, ill);
            m_tag = req1_tag;
         end
         m_valid = 1; m_data = d; m_src = w; m_ill = ill; m_ptr = !w;
         $display("xfer port%0d op=%0d a=%h b=%h tag=%0d -> data=%h illegal=%0b",
                  w, w ? req1_op : req0_op, w ? req1_a : req0_a, w ? req1_b : req0_b,
                  m_tag, d, ill);
      end else if (m_valid && res_ready) begin
         m_valid = 0;
      end
      @(posedge clk);
      #1;
      if (!hold_req) req_valid = req_valid & ~exp_g;
   endtask

   function automatic logic [31:0] rand_b(input logic [3:0] op, input logic [31:0] a);
      int sel;
      sel = $urandom_range(0, 3);
      if (op >= 4'd11 && op <= 4'd13) begin
         if (sel == 0) return 32'($urandom_range(0, 31));
         if (sel == 1) return 32'($urandom_range(32, 48));
         return $urandom;
      end
      if (sel == 0) return a;
      if (sel == 1) return 32'($urandom_range(0, 3));
      return $urandom;
   endfunction

   task automatic rand_req(input int p);
      logic [3:0]  op;
      logic [31:0] a;
      op = 4'($urandom_range(0, 15));
      a  = ($urandom_range(0, 3) == 0) ? {32{$urandom_range(0, 1) == 1}} : $urandom;
      set_req(p, op, a, rand_b(op, a), 5'($urandom_range(0, 31)));
   endtask

   initial begin
      rst_n = 0; res_ready = 1; req_valid = 2'b00;
      req0_op = '0; req1_op = '0; req0_a = '0; req0_b = '0;
      req1_a = '0; req1_b = '0; req0_tag = '0; req1_tag = '0;
      @(posedge clk); #1;
      step(); step();

      // Single request
      rst_n = 1;
      set_req(0, 4'd0, 32'd7, 32'd5, 5'd3);
      step(); step(); step();

      // Contention: both ports continuously valid
      hold_req = 1;
      set_req(0, 4'd1, 32'd10, 32'd3, 5'd1);
      set_req(1, 4'd9, 32'hFFFF_FFFF, 32'd1, 5'd2);
      repeat (5) step();
      hold_req = 0; req_valid = 2'b00;
      step();

      // Backpressure with an all-ones result held
      set_req(0, 4'd3, 32'hFFFF_FFFF, 32'd0, 5'd6);
      step();
      res_ready = 0;
      set_req(1, 4'd0, 32'd1, 32'd2, 5'd4);
      repeat (3) step();
      res_ready = 1;
      step(); step(); step();

      // Shift and unsigned compare boundaries
      set_req(0, 4'd13, 32'h8000_0000, 32'd40, 5'd10); step();
      set_req(1, 4'd11, 32'd1, 32'd32, 5'd11);          step();
      set_req(0, 4'd12, 32'h8000_0000, 32'd31, 5'd12); step();
      set_req(1, 4'd7, 32'hFFFF_FFFF, 32'd1, 5'd13);    step();
      step();

      // Illegal opcode still returns its tag and moves the pointer
      set_req(0, 4'd15, 32'h1234_5678, 32'd9, 5'd9); step(); step();
      set_req(0, 4'd14, 32'd1, 32'd1, 5'd5);
      set_req(1, 4'd0, 32'd2, 32'd2, 5'd7);
      step(); step(); step();

      // Reset while a result is held and both ports are waiting
      res_ready = 0;
      set_req(1, 4'd4, 32'hA5A5_0000, 32'h00FF_00FF, 5'd21);
      step();
      set_req(0, 4'd0, 32'd100, 32'd1, 5'd22);
      set_req(1, 4'd1, 32'd100, 32'd1, 5'd23);
      step();
      rst_n = 0; step();
      rst_n = 1; step();
      res_ready = 1;
      step(); step(); step();

      // Randomised traffic with backpressure and occasional resets
      for (int i = 0; i < 600; i++) begin
         for (int p = 0; p < 2; p++)
            if (!req_valid[p] && $urandom_range(0, 2) != 0) rand_req(p);
         res_ready = ($urandom_range(0, 3) != 0);
         rst_n     = ($urandom_range(0, 79) != 0);
         step();
      end
      rst_n = 1; req_valid = 2'b00; res_ready = 1;
      step(); step();

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
